// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a valid/ready handshake and a one-entry skid buffer.
// in_ready comes straight from a flop. Flush turns the stage into a NOP bubble.
module pipe_skid_reg #(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic               skid_valid;
    logic [PC_W-1:0]    skid_pc;
    logic [INSTR_W-1:0] skid_instr;
    logic               in_fire;
    logic               out_fire;
    logic               main_free;

    assign in_ready  = !skid_valid;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign main_free = !out_valid | out_fire;

    // The skid entry is always older than new input, so it refills main first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_instr  <= NOP_INSTR;
            skid_valid <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_instr  <= NOP_INSTR;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_pc     <= skid_pc;
                out_instr  <= skid_instr;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                out_valid <= 1'b1;
                out_pc    <= in_pc;
                out_instr <= in_instr;
            end else begin
                out_valid <= 1'b0;
                out_pc    <= '0;
                out_instr <= NOP_INSTR;
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
        end
    end

    // Skid payload is only meaningful while skid_valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (in_fire && !main_free) begin
            skid_pc    <= in_pc;
            skid_instr <= in_instr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: a queue model of the stage contents serves
// as scoreboard; a second narrow-counter instance with a non-zero NOP shares the stimulus.
module tb_pipe_skid_reg;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [15:0] stall_cnt;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_out_pc;
    logic [31:0] s_out_instr;
    logic [1:0]  s_stall_cnt;

    localparam logic [31:0] SMALL_NOP = 32'h0000_0013;

    entry_t sb[$];
    int     stall_exp;
    int     s_stall_exp;
    int     checks;
    int     errors;

    pipe_skid_reg dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .stall_cnt(stall_cnt)
    );

    pipe_skid_reg #(.CNT_W(2), .NOP_INSTR(SMALL_NOP)) dut_small (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc),
        .out_instr(s_out_instr), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic checkState();
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] esinstr;
        epc     = (sb.size() > 0) ? sb[0].pc : 32'h0;
        einstr  = (sb.size() > 0) ? sb[0].instr : 32'h0;
        esinstr = (sb.size() > 0) ? sb[0].instr : SMALL_NOP;
        checkOutput("out_valid", 64'(out_valid), 64'(sb.size() > 0));
        checkOutput("in_ready", 64'(in_ready), 64'(sb.size() < 2));
        checkOutput("out_pc", 64'(out_pc), 64'(epc));
        checkOutput("out_instr", 64'(out_instr), 64'(einstr));
        checkOutput("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
        checkOutput("s_out_valid", 64'(s_out_valid), 64'(sb.size() > 0));
        checkOutput("s_in_ready", 64'(s_in_ready), 64'(sb.size() < 2));
        checkOutput("s_out_pc", 64'(s_out_pc), 64'(epc));
        checkOutput("s_out_instr", 64'(s_out_instr), 64'(esinstr));
        checkOutput("s_stall_cnt", 64'(s_stall_cnt), 64'(s_stall_exp));
    endtask

    // Drive one cycle of stimulus, update the model, step one clock and check the result.
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
        entry_t e;
        entry_t exp_e;
        logic   fire_in;
        e.pc      = pc;
        e.instr   = $urandom;
        in_valid  = v;
        in_pc     = e.pc;
        in_instr  = e.instr;
        out_ready = ordy;
        flush     = fl;
        fire_in   = v && (sb.size() < 2);
        if (sb.size() > 0) begin
            if (ordy) begin
                exp_e = sb.pop_front();
                checkOutput("pop_pc", 64'(out_pc), 64'(exp_e.pc));
                checkOutput("pop_instr", 64'(out_instr), 64'(exp_e.instr));
            end else begin
                if (stall_exp < 65535) stall_exp++;
                if (s_stall_exp < 3) s_stall_exp++;
            end
        end
        if (fl) sb.delete();
        else if (fire_in) sb.push_back(e);
        @(posedge clk);
        #1;
        checkState();
    endtask

    task automatic pulseReset();
        #2 reset = 1'b1;
        #1;
        sb.delete();
        stall_exp   = 0;
        s_stall_exp = 0;
        checkState();
        #2 reset = 1'b0;
    endtask

    initial begin
        logic [31:0] pc;
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h0;
        in_instr  = 32'hE3A0_0001;
        out_ready = 1'b0;
        stall_exp   = 0;
        s_stall_exp = 0;
        #1;
        checkState();
        repeat (2) @(posedge clk);
        #1;
        checkState();
        reset = 1'b0;

        $display("[TB] streaming");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(i * 4), 1'b1, 1'b0);
        checkOutput("stream_stall", 64'(stall_cnt), 64'd0);
        repeat (2) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] back-pressure");
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h14, 1'b0, 1'b0);
        checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        checkOutput("bp_hold_pc", 64'(out_pc), 64'h10);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("bp_recover_pc", 64'(out_pc), 64'h14);
        checkOutput("bp_recover_rdy", 64'(in_ready), 64'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] stall counting");
        pulseReset();
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
            if (i == 5) checkOutput("stall_five", 64'(stall_cnt), 64'd5);
            if (i == 6) checkOutput("stall_sat", 64'(s_stall_cnt), 64'd3);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] flush with full stage");
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h204, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h208, 1'b0, 1'b1);
        checkOutput("flush_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_ready", 64'(in_ready), 64'd1);
        applyStimulus(1'b1, 32'h20C, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] async reset while full");
        applyStimulus(1'b1, 32'h280, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h284, 1'b0, 1'b0);
        pulseReset();
        applyStimulus(1'b1, 32'h300, 1'b1, 1'b0);
        checkOutput("post_reset_pc", 64'(out_pc), 64'h300);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] random traffic");
        pc = 32'h1000;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 19) == 0));
            pc = pc + 32'd4;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
